// File: rtl/pong_pkg.sv
// Shared Pong definitions: game FSM state encoding and default game constants.
package pong_pkg;

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_e;

    localparam int unsigned BALLS_DEF      = 3;
    localparam int unsigned WAIT_TICKS_DEF = 120;

endpackage : pong_pkg

// File: rtl/game_timer.sv
// Loadable down-counter decremented by frame ticks; saturates at zero.
module game_timer
    import pong_pkg::*;
#(
    parameter int unsigned WAIT_TICKS = WAIT_TICKS_DEF,
    parameter int unsigned TW         = $clog2(WAIT_TICKS + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic timer_up
);

    // A zero wait still needs a one-bit counter to hold the saturated value.
    localparam int unsigned CW = (TW == 0) ? 1 : TW;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CW'(WAIT_TICKS);
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timer_up = (count_q == '0);

endmodule : game_timer

// File: rtl/game_ctrl.sv
// Pong game-state controller: new game, play, re-serve and game over sequencing.
module game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned BALLS      = BALLS_DEF,
    parameter int unsigned WAIT_TICKS = WAIT_TICKS_DEF,
    parameter int unsigned BW         = $clog2(BALLS + 1),
    parameter int unsigned TW         = $clog2(WAIT_TICKS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    btn,
    input  logic          refr_tick,
    input  logic          hit,
    input  logic          miss,
    output logic          d_inc,
    output logic          d_clr,
    output logic          gra_still,
    output logic [BW-1:0] balls_left,
    output logic          game_over
);

    state_e        state_q;
    state_e        state_d;
    logic [BW-1:0] balls_q;
    logic [BW-1:0] balls_d;
    logic          timer_load;
    logic          timer_up;

    game_timer #(
        .WAIT_TICKS (WAIT_TICKS),
        .TW         (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .tick     (refr_tick),
        .timer_up (timer_up)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= NEWGAME;
            balls_q <= BW'(BALLS);
        end else begin
            state_q <= state_d;
            balls_q <= balls_d;
        end
    end

    // Next state, ball count and timer load; miss takes priority over hit.
    always_comb begin
        state_d    = state_q;
        balls_d    = balls_q;
        timer_load = 1'b0;
        case (state_q)
            NEWGAME: begin
                balls_d = BW'(BALLS);
                if (btn != 2'b00) begin
                    state_d = PLAY;
                    balls_d = BW'(BALLS - 1);
                end
            end
            PLAY: begin
                if (miss) begin
                    timer_load = 1'b1;
                    if (balls_q == '0) begin
                        state_d = OVER;
                    end else begin
                        state_d = NEWBALL;
                        balls_d = balls_q - BW'(1);
                    end
                end
            end
            NEWBALL: begin
                if (timer_up && (btn != 2'b00)) begin
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (timer_up) begin
                    state_d = NEWGAME;
                    balls_d = BW'(BALLS);
                end
            end
        endcase
    end

    always_comb begin
        d_inc     = 1'b0;
        d_clr     = 1'b0;
        gra_still = 1'b1;
        game_over = 1'b0;
        case (state_q)
            NEWGAME: d_clr = 1'b1;
            PLAY: begin
                gra_still = 1'b0;
                d_inc     = hit && !miss;
            end
            NEWBALL: gra_still = 1'b1;
            OVER:    game_over = 1'b1;
        endcase
    end

    assign balls_left = balls_q;

endmodule : game_ctrl
